// File: rtl/bt656_sync_tracker.sv
// ---------------------------------------------------------------------------
// bt656_sync_tracker
//
// Finds BT.656 timing reference codes (3FF/000/000 + XY) in a word stream,
// decodes F/V/H from accepted XY words, tracks the word position within a
// line and the line position within a frame, and runs a lock state machine
// that qualifies the sync outputs for downstream line pipelines.
//
// Optional build macro:
//   SYNC_XY_ECC_EN  - when defined, single-bit XY errors (bits 6..0) are
//                     corrected and the code accepted (still counted as an
//                     error); otherwise any protection mismatch rejects it.
//
// Ports:
//   clk         pixel clock, one word per cycle
//   reset       asynchronous, active-high reset
//   bt_656      BT.656 word stream (only the top 8 bits are compared)
//   H, V, F     flags from the last accepted timing code
//   sav_pulse   one-cycle pulse for an accepted SAV
//   eav_pulse   one-cycle pulse for an accepted EAV
//   word_count  words since the last accepted EAV (0 while eav_pulse is high)
//   line_count  line index within the frame
//   locked      EAV spacing has been verified; consumers gate on this
//   err_count   saturating count of bad codes and lost/misplaced EAVs
// ---------------------------------------------------------------------------
module bt656_sync_tracker #(
   parameter int DATA_WIDTH      = 10,
   parameter int LINE_WORDS      = 1716,
   parameter int LINES_PER_FRAME = 525,
   parameter int LOCK_COUNT      = 4,
   parameter int UNLOCK_COUNT    = 2
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic [DATA_WIDTH-1:0]              bt_656,
   output logic                               H,
   output logic                               V,
   output logic                               F,
   output logic                               sav_pulse,
   output logic                               eav_pulse,
   output logic [$clog2(LINE_WORDS)-1:0]      word_count,
   output logic [$clog2(LINES_PER_FRAME)-1:0] line_count,
   output logic                               locked,
   output logic [15:0]                        err_count
);

   localparam int WC_W = $clog2(LINE_WORDS);
   localparam int LC_W = $clog2(LINES_PER_FRAME);
   localparam int GC_W = $clog2(LOCK_COUNT + 1);
   localparam int MC_W = $clog2(UNLOCK_COUNT + 1);

   localparam logic [WC_W-1:0] WC_LAST   = WC_W'(LINE_WORDS - 1);
   localparam logic [LC_W-1:0] LC_LAST   = LC_W'(LINES_PER_FRAME - 1);
   localparam logic [GC_W-1:0] GOOD_LAST = GC_W'(LOCK_COUNT - 1);
   localparam logic [MC_W-1:0] MISS_LAST = MC_W'(UNLOCK_COUNT - 1);

   typedef enum logic [1:0] {
      SEARCH = 2'd0,
      VERIFY = 2'd1,
      LOCKED = 2'd2
   } state_t;

   state_t          state, state_next;
   logic [GC_W-1:0] good_count, good_next;
   logic [MC_W-1:0] miss_count, miss_next;

   logic [7:0] word;
   logic [7:0] hist0, hist1, hist2;   // hist2 is the oldest word
   logic       preamble;
   logic [3:0] p_calc, syndrome;
   logic [2:0] fvh;                   // {F, V, H} after optional correction
   logic       code_ok, corrected, rejected;
   logic       acc_eav, acc_sav;
   logic       at_last, miss_evt;
   logic [1:0] err_inc;
   logic [16:0] err_sum;

   // Only the top 8 bits carry the code; 10-bit LSBs are ignored.
   assign word = bt_656[DATA_WIDTH-1 -: 8];

   generate
      if (DATA_WIDTH > 8) begin : g_lsb
         logic unused_lsbs;
         assign unused_lsbs = ^bt_656[DATA_WIDTH-9:0];
      end
   endgenerate

   assign preamble = (hist2 == 8'hFF) && (hist1 == 8'h00) && (hist0 == 8'h00);

   // NOTE: every signal driven in an always_comb gets a default at the top,
   // so no path through the block can leave it unassigned and infer a latch.
   always_comb begin
      p_calc    = {word[5] ^ word[4], word[6] ^ word[4],
                   word[6] ^ word[5], word[6] ^ word[5] ^ word[4]};
      syndrome  = p_calc ^ word[3:0];
      fvh       = word[6:4];
      code_ok   = 1'b0;
      corrected = 1'b0;
      if (preamble && word[7]) begin
         if (syndrome == 4'b0000) begin
            code_ok = 1'b1;
         end
`ifdef SYNC_XY_ECC_EN
         else begin
            // Each single-bit error has a distinct odd-weight syndrome;
            // double errors give an even-weight one and are rejected.
            code_ok   = 1'b1;
            corrected = 1'b1;
            case (syndrome)
               4'b0111: fvh[2] = ~fvh[2];
               4'b1011: fvh[1] = ~fvh[1];
               4'b1101: fvh[0] = ~fvh[0];
               4'b0001, 4'b0010, 4'b0100, 4'b1000: ; // a protection bit was hit
               default: begin
                  code_ok   = 1'b0;
                  corrected = 1'b0;
               end
            endcase
         end
`endif
      end
   end

   assign rejected = preamble && !code_ok;
   assign acc_eav  = code_ok && fvh[0];
   assign acc_sav  = code_ok && !fvh[0];
   assign at_last  = (word_count == WC_LAST);

   // Lock qualification. Decisions are taken in the cycle the XY word is
   // present, so state (and locked) changes together with the EAV pulse.
   always_comb begin
      state_next = state;
      good_next  = good_count;
      miss_next  = miss_count;
      miss_evt   = 1'b0;
      case (state)
         SEARCH: begin
            if (acc_eav) begin
               state_next = VERIFY;
               good_next  = GC_W'(1);
            end
         end
         VERIFY: begin
            if (acc_eav) begin
               if (!at_last) begin
                  good_next = GC_W'(1);
               end else if (good_count == GOOD_LAST) begin
                  state_next = LOCKED;
                  miss_next  = '0;
               end else begin
                  good_next = good_count + GC_W'(1);
               end
            end
         end
         LOCKED: begin
            if (acc_eav && at_last) begin
               miss_next = '0;
            end else if (acc_eav || at_last) begin
               // Misplaced EAV or a wrap with no EAV; never both at once.
               miss_evt = 1'b1;
               if (miss_count == MISS_LAST) begin
                  state_next = SEARCH;
                  miss_next  = '0;
               end else begin
                  miss_next = miss_count + MC_W'(1);
               end
            end
         end
         default: state_next = SEARCH;
      endcase
   end

   assign err_inc = 2'(rejected | corrected) + 2'(miss_evt);
   assign err_sum = {1'b0, err_count} + 17'(err_inc);
   assign locked  = (state == LOCKED);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of statement order.
   // NOTE: the three-word preamble history is reset along with everything
   // else, so a stale FF/00/00 cannot pair with the first word after reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= SEARCH;
         good_count <= '0;
         miss_count <= '0;
         hist0      <= '0;
         hist1      <= '0;
         hist2      <= '0;
         H          <= 1'b0;
         V          <= 1'b0;
         F          <= 1'b0;
         sav_pulse  <= 1'b0;
         eav_pulse  <= 1'b0;
         word_count <= '0;
         line_count <= '0;
         err_count  <= '0;
      end else begin
         state      <= state_next;
         good_count <= good_next;
         miss_count <= miss_next;
         hist2      <= hist1;
         hist1      <= hist0;
         hist0      <= word;
         sav_pulse  <= acc_sav;
         eav_pulse  <= acc_eav;
         err_count  <= err_sum[16] ? 16'hFFFF : err_sum[15:0];

         if (code_ok) begin
            F <= fvh[2];
            V <= fvh[1];
            H <= fvh[0];
         end

         if (acc_eav || at_last) begin
            word_count <= '0;
         end else begin
            word_count <= word_count + WC_W'(1);
         end

         if (acc_eav) begin
            if (F && !fvh[2]) begin
               line_count <= '0;          // F falling marks frame start
            end else if (line_count == LC_LAST) begin
               line_count <= '0;
            end else begin
               line_count <= line_count + LC_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_bt656_sync_tracker.sv
// ---------------------------------------------------------------------------
// tb_bt656_sync_tracker
//
// Drives two reduced-size trackers: dut_a (10-bit words, 20 words/line,
// 7 lines/frame) and dut_b (8-bit words, 22 words/line, 11 lines/frame).
// Both receive the same word stream; use8 selects which one is checked.
// ---------------------------------------------------------------------------
module tb_bt656_sync_tracker;

   localparam int LW_A  = 20;
   localparam int LPF_A = 7;
   localparam int LW_B  = 22;
   localparam int LPF_B = 11;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [9:0] bt_a = 10'h081;
   logic [7:0] bt_b = 8'h20;

   logic        h_a, v_a, f_a, sav_a, eav_a, locked_a;
   logic [4:0]  wc_a;
   logic [2:0]  lc_a;
   logic [15:0] err_a;
   logic        h_b, v_b, f_b, sav_b, eav_b, locked_b;
   logic [4:0]  wc_b;
   logic [3:0]  lc_b;
   logic [15:0] err_b;

   always #5 clk = ~clk;

   bt656_sync_tracker #(
      .DATA_WIDTH(10), .LINE_WORDS(LW_A), .LINES_PER_FRAME(LPF_A),
      .LOCK_COUNT(4), .UNLOCK_COUNT(2)
   ) dut_a (
      .clk(clk), .reset(reset), .bt_656(bt_a),
      .H(h_a), .V(v_a), .F(f_a), .sav_pulse(sav_a), .eav_pulse(eav_a),
      .word_count(wc_a), .line_count(lc_a), .locked(locked_a), .err_count(err_a)
   );

   bt656_sync_tracker #(
      .DATA_WIDTH(8), .LINE_WORDS(LW_B), .LINES_PER_FRAME(LPF_B),
      .LOCK_COUNT(4), .UNLOCK_COUNT(2)
   ) dut_b (
      .clk(clk), .reset(reset), .bt_656(bt_b),
      .H(h_b), .V(v_b), .F(f_b), .sav_pulse(sav_b), .eav_pulse(eav_b),
      .word_count(wc_b), .line_count(lc_b), .locked(locked_b), .err_count(err_b)
   );

   bit use8 = 1'b0;
   logic eav_s, sav_s, locked_s, h_s, v_s, f_s;
   int   wc_s, lc_s, err_s;
   assign eav_s    = use8 ? eav_b    : eav_a;
   assign sav_s    = use8 ? sav_b    : sav_a;
   assign locked_s = use8 ? locked_b : locked_a;
   assign h_s      = use8 ? h_b      : h_a;
   assign v_s      = use8 ? v_b      : v_a;
   assign f_s      = use8 ? f_b      : f_a;
   assign wc_s     = use8 ? int'(wc_b)  : int'(wc_a);
   assign lc_s     = use8 ? int'(lc_b)  : int'(lc_a);
   assign err_s    = use8 ? int'(err_b) : int'(err_a);

   int n_vec = 0;
   int n_bad = 0;
   int n_eav = 0;

   // Values captured around the EAV slot (word 3) of the last line sent.
   logic pre_locked, s_locked, s_f;
   int   pre_wc, s_wc, s_lc, s_err;

   typedef struct {
      logic [7:0] xy;
      logic [4:0] exp_flags;   // {eav_pulse, sav_pulse, H, V, F}
      int         exp_err;     // cumulative err_count
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] xy_of(input logic f, input logic v, input logic h);
      return {1'b1, f, v, h, v ^ h, f ^ h, f ^ v, f ^ v ^ h};
   endfunction

   // Present one word for one clock; outputs are sampled 1 time unit after
   // the rising edge that consumed it. The 10-bit stream carries nonzero LSBs.
   task automatic put(input logic [7:0] w);
      bt_a = {w, 2'b01};
      bt_b = w;
      @(posedge clk);
      #1;
      if (eav_s) n_eav++;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      bt_a  = 10'h081;
      bt_b  = 8'h20;
      repeat (2) @(negedge clk);
      reset = 1'b0;
   endtask

   // One line: EAV at words 0..3, blanking, SAV at words 8..11, active video.
   task automatic send_line(input logic f, input logic v, input bit with_eav, input int nwords);
      for (int t = 0; t < nwords; t++) begin
         logic [7:0] w;
         case (t)
            0:       w = with_eav ? 8'hFF : 8'h20;
            1, 2:    w = with_eav ? 8'h00 : 8'h20;
            3:       w = with_eav ? xy_of(f, v, 1'b1) : 8'h20;
            8:       w = 8'hFF;
            9, 10:   w = 8'h00;
            11:      w = xy_of(f, v, 1'b0);
            default: w = (t < 8) ? 8'h20 : 8'h80;
         endcase
         if (t == 3) begin
            pre_locked = locked_s;
            pre_wc     = wc_s;
         end
         put(w);
         if (t == 3) begin
            s_locked = locked_s;
            s_wc     = wc_s;
            s_lc     = lc_s;
            s_err    = err_s;
            s_f      = f_s;
         end
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int exp_lc;
      logic prev_f;

      // Decode table; rejected codes leave H/V/F at their previous values.
      vecs[0]  = '{8'h80, 5'b01000, 0};
      vecs[1]  = '{8'h9D, 5'b10100, 0};
`ifdef SYNC_XY_ECC_EN
      vecs[2]  = '{8'h9C, 5'b10100, 1};   // P0 flipped, corrected to 9D
      vecs[3]  = '{8'hAB, 5'b01010, 1};
      vecs[4]  = '{8'h8D, 5'b10100, 2};   // H flipped, corrected to 9D
      vecs[5]  = '{8'hAC, 5'b01011, 3};   // F flipped, corrected to EC
`else
      vecs[2]  = '{8'h9C, 5'b00100, 1};
      vecs[3]  = '{8'hAB, 5'b01010, 1};
      vecs[4]  = '{8'h8D, 5'b00010, 2};
      vecs[5]  = '{8'hAC, 5'b00010, 3};
`endif
      vecs[6]  = '{8'hF1, 5'b10111, 3};
      vecs[7]  = '{8'h9E, 5'b00111, 4};   // double error, always rejected
      vecs[8]  = '{8'h1D, 5'b00111, 5};   // bit 7 clear
      vecs[9]  = '{8'hC7, 5'b01001, 5};
      vecs[10] = '{8'hDA, 5'b10101, 5};

      // Reset state of both instances.
      #2;
      check("reset_state_a", 32'({h_a, v_a, f_a, sav_a, eav_a, wc_a, lc_a, locked_a, err_a}), 32'd0);
      check("reset_state_b", 32'({h_b, v_b, f_b, sav_b, eav_b, wc_b, lc_b, locked_b, err_b}), 32'd0);

      // word_count free-runs and wraps with no EAV present.
      do_reset();
      for (int k = 1; k <= LW_A + 1; k++) begin
         put(8'h80);
         if (k == LW_A - 1) check("wc_before_wrap", 32'(wc_s), 32'(LW_A - 1));
         if (k == LW_A)     check("wc_wrap", 32'(wc_s), 32'd0);
      end

      // XY decode / protection table.
      for (int i = 0; i < 11; i++) begin
         put(8'hFF);
         put(8'h00);
         put(8'h00);
         put(vecs[i].xy);
         check($sformatf("xy_%02h_flags", vecs[i].xy),
               32'({eav_s, sav_s, h_s, v_s, f_s}), 32'(vecs[i].exp_flags));
         check($sformatf("xy_%02h_err", vecs[i].xy), 32'(err_s), 32'(vecs[i].exp_err));
         put(8'h20);
         check($sformatf("xy_%02h_pulse_width", vecs[i].xy), 32'({eav_s, sav_s}), 32'd0);
      end

      // Clean stream, two frames: lock timing and line numbering.
      do_reset();
      n_eav  = 0;
      exp_lc = 0;
      prev_f = 1'b0;
      for (int fr = 0; fr < 2; fr++) begin
         for (int ln = 0; ln < LPF_A; ln++) begin
            logic f;
            int idx;
            f   = (ln >= 4);
            idx = fr * LPF_A + ln;
            send_line(f, ln < 2, 1'b1, LW_A);
            if (prev_f && !f) exp_lc = 0;
            else exp_lc = (exp_lc == LPF_A - 1) ? 0 : exp_lc + 1;
            prev_f = f;
            if (idx == 3) check("clean_locked_before_4th", 32'(pre_locked), 32'd0);
            check($sformatf("clean_locked_l%0d", idx), 32'(s_locked), 32'(idx >= 3));
            check($sformatf("clean_lc_l%0d", idx), 32'(s_lc), 32'(exp_lc));
            check($sformatf("clean_f_l%0d", idx), 32'(s_f), 32'(f));
         end
      end
      check("clean_eav_total", 32'(n_eav), 32'(2 * LPF_A));
      check("clean_err", 32'(err_s), 32'd0);

      // Two consecutive EAVs deleted while locked, then relock.
      do_reset();
      for (int i = 0; i < 5; i++) send_line(1'b0, 1'b0, 1'b1, LW_A);
      check("drop_locked_start", 32'(s_locked), 32'd1);
      send_line(1'b0, 1'b0, 1'b0, LW_A);
      check("drop1_err", 32'(s_err), 32'd1);
      check("drop1_locked", 32'(s_locked), 32'd1);
      send_line(1'b0, 1'b0, 1'b0, LW_A);
      check("drop2_locked_before", 32'(pre_locked), 32'd1);
      check("drop2_locked_after", 32'(s_locked), 32'd0);
      check("drop2_err", 32'(s_err), 32'd2);
      for (int i = 0; i < 4; i++) begin
         send_line(1'b0, 1'b0, 1'b1, LW_A);
         check($sformatf("relock_l%0d", i), 32'(s_locked), 32'(i == 3));
      end
      check("relock_err", 32'(s_err), 32'd2);

      // One early EAV while locked: resync, single miss, then miss cleared.
      do_reset();
      for (int i = 0; i < 5; i++) send_line(1'b0, 1'b0, 1'b1, LW_A);
      send_line(1'b0, 1'b0, 1'b1, 8);
      send_line(1'b0, 1'b0, 1'b1, LW_A);
      check("early_wc_at_detect", 32'(pre_wc), 32'd7);
      check("early_wc_resync", 32'(s_wc), 32'd0);
      check("early_err", 32'(s_err), 32'd1);
      check("early_locked", 32'(s_locked), 32'd1);
      send_line(1'b0, 1'b0, 1'b1, LW_A);
      check("early_next_locked", 32'(s_locked), 32'd1);
      check("early_next_err", 32'(s_err), 32'd1);
      send_line(1'b0, 1'b0, 1'b1, 8);
      send_line(1'b0, 1'b0, 1'b1, LW_A);
      check("early2_err", 32'(s_err), 32'd2);
      check("early2_locked", 32'(s_locked), 32'd1);

      // Asynchronous reset in the middle of line 10, then reacquire.
      do_reset();
      for (int i = 0; i < 10; i++) send_line(1'b0, 1'b0, 1'b1, LW_A);
      send_line(1'b0, 1'b0, 1'b1, 12);
      check("midreset_locked_before", 32'(locked_a), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      check("midreset_outputs", 32'({h_a, v_a, f_a, sav_a, eav_a, wc_a, lc_a, locked_a, err_a}), 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 5; i++) begin
         send_line(1'b0, 1'b0, 1'b1, LW_A);
         check($sformatf("midreset_relock_l%0d", i), 32'(s_locked), 32'(i >= 3));
      end

      // 8-bit instance, longer lines: same lock timing, line_count wraps.
      use8 = 1'b1;
      do_reset();
      for (int i = 0; i < LPF_B + 1; i++) begin
         send_line(1'b0, 1'b0, 1'b1, LW_B);
         check($sformatf("w8_locked_l%0d", i), 32'(s_locked), 32'(i >= 3));
         check($sformatf("w8_lc_l%0d", i), 32'(s_lc), 32'((i + 1) % LPF_B));
      end
      check("w8_err", 32'(err_s), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/bt656_sync_tracker.md
Name: bt656_sync_tracker

Overview:
- Parametrised successor to sync_parser for the TVP5147M1 decoder interface.
- Detects BT.656 timing reference codes (preamble 3FF/000/000 + XY) and decodes F/V/H.
- Validates XY protection bits; tracks word-in-line and line-in-frame positions.
- Lock state machine qualifies sync outputs; feeds the scrambler/descrambler line pipeline.

Parameters:
DATA_WIDTH, 10, input word width; legal 8 or 10; compare only the top 8 bits
LINE_WORDS, 1716, words per line, EAV to EAV (2*858 for 525/60)
LINES_PER_FRAME, 525, lines per frame
LOCK_COUNT, 4, consecutive correctly spaced EAVs needed to lock
UNLOCK_COUNT, 2, consecutive missed or misplaced EAVs needed to drop lock

Ports:
clk  in  1  pixel clock; one word per cycle
reset  in  1  asynchronous, active-high reset
bt_656  in  DATA_WIDTH  BT.656 word stream
H  out  1  decoded H bit from last accepted code
V  out  1  decoded V bit
F  out  1  decoded F bit
sav_pulse  out  1  one-cycle pulse on an accepted SAV
eav_pulse  out  1  one-cycle pulse on an accepted EAV
word_count  out  $clog2(LINE_WORDS)  words since last accepted EAV
line_count  out  $clog2(LINES_PER_FRAME)  line index in frame
locked  out  1  tracker locked
err_count  out  16  saturating error counter

Behaviour:
- Reset: all outputs 0; state SEARCH; 3-word preamble history cleared.
- Detection:
  - Candidate code = three previous top-8-bit words FF, 00, 00.
  - The current word is XY; bit7 must be 1.
  - F = XY[6], V = XY[5], H = XY[4].
  - Protection: P3=V^H, P2=F^H, P1=F^V, P0=F^V^H, checked against XY[3:0].
- Accepted code, latency 1: XY sampled at cycle n; at n+1 H/V/F update and eav_pulse (H=1) or sav_pulse (H=0) asserts for exactly one cycle.
- Rejected code: H/V/F hold; no pulse; err_count += 1.
- word_count:
  - Increments every cycle.
  - Loads 0 in the cycle eav_pulse is high.
  - If no EAV arrives, wraps LINE_WORDS-1 -> 0.
- line_count:
  - Increments on each eav_pulse; wraps LINES_PER_FRAME-1 -> 0.
  - Forced to 0 on an eav_pulse where F goes 1 -> 0 (start of frame).
- State machine:
  - SEARCH: first accepted EAV -> VERIFY, good-count = 1.
  - VERIFY:
    - EAV with word_count == LINE_WORDS-1 at detection: good-count++.
    - good-count reaching LOCK_COUNT -> LOCKED; locked = 1 from the next cycle.
    - Misplaced EAV: good-count = 1, stay in VERIFY.
  - LOCKED:
    - Miss = word_count wraps without an EAV, or an EAV at any other position.
    - Each miss: miss-count++ and err_count++.
    - Correctly placed EAV: miss-count = 0.
    - miss-count == UNLOCK_COUNT -> SEARCH; locked = 0 next cycle.
  - In SEARCH/VERIFY, H/V/F and pulses still follow accepted codes. Consumers must gate on locked.
- Simultaneous events: a misplaced EAV in LOCKED still resyncs word_count to 0 and counts as a miss; it does not also count as a wrap miss.
- err_count saturates at 16'hFFFF; cleared only by reset.
- Reset asserted mid-line: immediate return to reset values; reacquisition starts from SEARCH.
- DATA_WIDTH=8: compare bt_656[7:0]; no LSB padding assumed.

Optional Feature:
SYNC_XY_ECC_EN
- Defined: a single-bit XY error (bits 6..0) is corrected via the BT.656 syndrome table. The corrected code is accepted and err_count still increments. Double errors are rejected.
- Undefined: any protection mismatch rejects the code.

Test Plan:
1. Clean 525-line stream, 2 frames, 1716 words/line -> eav_pulse 1050 times. locked = 1 one cycle after the 4th EAV (line index 3) and stays high. err_count = 0. line_count = 0 at every F 1->0.
2. XY 0x9D (F=0, V=0, H=1) with P0 flipped to 0x9C -> ECC off: no pulse, H holds, err_count = 1. ECC on: eav_pulse, H = 1, err_count = 1.
3. While locked, delete two consecutive EAVs -> err_count = 2, locked falls 1 cycle after the second wrap; relock after 4 good lines.
4. While locked, insert one EAV at word_count = 800 -> word_count resyncs to 0, err_count = 1, locked stays 1; the next correctly spaced EAV clears miss-count.
5. Assert reset at word 900 of line 10 -> all outputs 0 next edge. After release, locked = 1 after the 4th subsequent EAV.
6. Run case 1 with DATA_WIDTH = 8 and LINE_WORDS = 1728, LINES_PER_FRAME = 625 (625-line stream) -> same lock timing; line_count wraps at 624.
